data_memory_unit: RTL and testbench
===================================

# data_memory_unit

Parametrised, byte-addressed, big-endian data memory for the MIPS datapath, replacing the fixed 125-byte word-only array. Supports byte, halfword and word access with sign or zero extension on loads, and models a configurable wait-state latency behind a request/ready handshake. Sits between the MEM stage controller and the data store. Only one access is in flight at a time.

## Interface
- DEPTH_BYTES, 128, storage size in bytes; power of two, at least 4
- LATENCY, 2, wait states between accept and completion, range 0..15
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  reset, asynchronous, active-high
- Req  input  1  access request; sampled only while Busy=0
- WEn  input  1  1 = store, 0 = load; captured with Req
- Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- Unsigned  input  1  load extension: 1 = zero-extend, 0 = sign-extend
- Address  input  32  byte address; captured with Req
- Wdata  input  32  store data; byte uses [7:0], halfword uses [15:0]
- Busy  output  1  access in flight; Req ignored while high
- Ready  output  1  one-cycle completion pulse
- Rdata  output  32  load result; valid with Ready, held until next completion
- Fault  output  1  access rejected; valid with Ready

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: at an edge with Req=1, capture WEn, Size, Unsigned, Address and Wdata. Load the wait counter with LATENCY, set Busy=1, and go to WAIT.
- WAIT: decrement the counter each edge. When the counter is 0, go to DONE at the next edge.
- DONE: perform the access at the edge entering DONE.
  - Stores: write memory.
  - Loads: update Rdata.
  - Set Ready=1 and Busy=0. Fault=1 only if the access is rejected.
- DONE returns to IDLE after one cycle. DONE behaves as IDLE for Req, so a Req during the Ready cycle is accepted.
- Byte order is big-endian, with A = captured address:
  - Word: {m[A], m[A+1], m[A+2], m[A+3]}.
  - Halfword: {m[A], m[A+1]}, extended to 32 bits.
  - Byte: m[A], extended to 32 bits.
- Stores use the same ordering. Store width is exactly the access size; neighbouring bytes are untouched.
- Completion of a store leaves Rdata unchanged.
- Memory contents are not affected by RST.

## Timing
- Accept edge E0. Completion edge is E0+LATENCY+1; Ready is high for the single cycle that follows.
- Throughput: one access per LATENCY+2 cycles with back-to-back Req.
- Busy is high from after E0 until the completion edge.
- Reset values: Busy=0, Ready=0, Fault=0, Rdata=0, state IDLE, counter 0.
- Reset mid-operation: the in-flight access is discarded, so a pending store never writes. Reset takes effect immediately, without waiting for CLK.
- Input changes while Busy=1 have no effect on the in-flight access.

## Configuration
- DMEM_FAULT_CHECK_EN defined:
  - An access is rejected if it is misaligned (halfword with A[0]=1, or word with A[1:0]≠0).
  - An access is rejected if it is out of range (A + size_bytes > DEPTH_BYTES).
  - An access is rejected if Size=11.
  - A rejected access completes with normal timing and Fault=1. It does not write memory, and it sets Rdata=0 for both loads and stores.
- DMEM_FAULT_CHECK_EN undefined:
  - Fault is tied to 0.
  - Size=11 is treated as word.
  - Each byte index is computed as (A+i) mod DEPTH_BYTES, so misaligned accesses are legal and wrap at the top of memory.

## Test plan
- Reset, then LATENCY=2, store word 0x8C610001 at A=0, then load word at A=0. Required: Ready exactly 3 cycles after each accept edge, and Rdata=0x8C610001.
- Store byte 0x80 at A=5, then signed byte load at A=5, then unsigned byte load at A=5. Required: 0xFFFFFF80, then 0x00000080; bytes 4, 6 and 7 unchanged.
- Store halfword 0x1234 at A=6, then load word at A=4. Required: bytes 6 and 7 equal 0x12 and 0x34; signed halfword load at A=6 returns 0x00001234.
- With the macro defined: load word at A=2 and store word at A=DEPTH_BYTES. Required: both give Ready with Fault=1 and Rdata=0, and memory is unchanged.
- With the macro undefined, DEPTH_BYTES=128: store word 0xAABBCCDD at A=126. Required: m[126]=AA, m[127]=BB, m[0]=CC, m[1]=DD, and Fault=0.
- Assert RST one cycle after accepting a store. Required: Busy, Ready and Rdata go to 0 immediately, and a later load of that address shows the old data.

Source files
------------

// File: rtl/data_memory_unit.sv
// Byte-addressed big-endian data memory with wait-state latency behind a Req/Ready handshake.
// Optional `DMEM_FAULT_CHECK_EN rejects misaligned, out-of-range and reserved-size accesses.
module data_memory_unit #(
  parameter int DEPTH_BYTES = 128,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req,
  input  logic        WEn,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] Wdata,
  output logic        Busy,
  output logic        Ready,
  output logic [31:0] Rdata,
  output logic        Fault,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = $clog2(DEPTH_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: Req is sampled at a rising edge only while Busy=0 (IDLE or DONE).
  // Ready pulses for exactly one cycle after the completion edge; Rdata and
  // Fault are valid with it and Rdata holds until the next completion.

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wen_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  logic [7:0]  mem [DEPTH_BYTES];

  logic        accept, complete, reject, mem_we;
  logic [1:0]  eff_size;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] load_val;

  assign accept   = (state_q != S_WAIT) && Req;
  assign complete = (state_q == S_WAIT) && (cnt_q == 4'd0);

`ifdef DMEM_FAULT_CHECK_EN
  logic [2:0] nbytes;
  logic       misalign, out_of_range;

  assign eff_size     = size_q;
  assign nbytes       = (size_q == 2'b00) ? 3'd1 : (size_q == 2'b01) ? 3'd2 : 3'd4;
  assign misalign     = ((size_q == 2'b01) && addr_q[0]) ||
                        ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
  assign out_of_range = ({1'b0, addr_q} + {30'd0, nbytes}) > 33'(DEPTH_BYTES);
  assign reject       = misalign || out_of_range || (size_q == 2'b11);
`else
  logic unused_addr_hi;

  // Reserved size falls back to a word access; indices wrap modulo the depth.
  assign eff_size       = (size_q == 2'b11) ? 2'b10 : size_q;
  assign reject         = 1'b0;
  assign unused_addr_hi = ^addr_q[31:AW];
`endif

  assign idx0 = addr_q[AW-1:0];
  assign idx1 = addr_q[AW-1:0] + AW'(1);
  assign idx2 = addr_q[AW-1:0] + AW'(2);
  assign idx3 = addr_q[AW-1:0] + AW'(3);

  assign b0 = mem[idx0];
  assign b1 = mem[idx1];
  assign b2 = mem[idx2];
  assign b3 = mem[idx3];

  always_comb begin
    load_val = {b0, b1, b2, b3};
    case (eff_size)
      2'b00:   load_val = uns_q ? {24'd0, b0} : {{24{b0[7]}}, b0};
      2'b01:   load_val = uns_q ? {16'd0, b0, b1} : {{16{b0[7]}}, b0, b1};
      default: load_val = {b0, b1, b2, b3};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    fault_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (Req) begin
          state_d = S_WAIT;
          cnt_d   = 4'(LATENCY);
          busy_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          fault_d = reject;
          if (reject)      rdata_d = 32'd0;
          else if (!wen_q) rdata_d = load_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'd0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      if (accept) begin
        wen_q   <= WEn;
        uns_q   <= Unsigned;
        size_q  <= Size;
        addr_q  <= Address;
        wdata_q <= Wdata;
      end
    end
  end

  // Storage is not reset; a reset clears state_q, so no pending store can reach here.
  assign mem_we = complete && wen_q && !reject;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      case (eff_size)
        2'b00: mem[idx0] <= wdata_q[7:0];
        2'b01: begin
          mem[idx0] <= wdata_q[15:8];
          mem[idx1] <= wdata_q[7:0];
        end
        default: begin
          mem[idx0] <= wdata_q[31:24];
          mem[idx1] <= wdata_q[23:16];
          mem[idx2] <= wdata_q[15:8];
          mem[idx3] <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign Busy        = busy_q;
  assign Ready       = ready_q;
  assign Rdata       = rdata_q;
  assign Fault       = fault_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: expected load results queue up at issue
// and are compared when Ready arrives.
module tb_data_memory_unit;

  localparam int DEPTH = 128;
  localparam int LAT   = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Req, WEn, Unsigned;
  logic [1:0]  Size;
  logic [31:0] Address, Wdata;
  logic        Busy, Ready, Fault;
  logic [31:0] Rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic        exp_fq[$];
  logic [31:0] model_rd;

  data_memory_unit #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST), .Req(Req), .WEn(WEn), .Size(Size),
    .Unsigned(Unsigned), .Address(Address), .Wdata(Wdata),
    .Busy(Busy), .Ready(Ready), .Rdata(Rdata), .Fault(Fault),
    .dbg_state_o(dbg_state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where Ready is observed.
  task automatic access(input string tag, input logic wen, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_load, input logic exp_f);
    int k;
    logic busy_ok;
    logic [31:0] e;
    Req = 1'b1; WEn = wen; Size = sz; Unsigned = uns; Address = a; Wdata = wd;
    e = wen ? (exp_f ? 32'd0 : model_rd) : (exp_f ? 32'd0 : exp_load);
    exp_q.push_back(e);
    exp_fq.push_back(exp_f);
    @(posedge CLK);
    #1;
    Req = 1'b0;
    WEn = 1'($urandom_range(0, 1));
    Size = 2'($urandom_range(0, 3));
    Unsigned = 1'($urandom_range(0, 1));
    Address = $urandom;
    Wdata = $urandom;
    k = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge CLK);
      k++;
      if (Ready ? Busy : !Busy) busy_ok = 1'b0;
    end while (!Ready && k < 20);
    if (!Ready) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_ready expected=ready", tag);
      void'(exp_q.pop_front());
      void'(exp_fq.pop_front());
      return;
    end
    check({tag, "_lat"}, 32'(k - 1), 32'(LAT + 1));
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_state"}, {30'd0, dbg_state}, 32'd2);
    e = exp_q.pop_front();
    check({tag, "_rdata"}, Rdata, e);
    check({tag, "_fault"}, {31'd0, Fault}, {31'd0, exp_fq.pop_front()});
    model_rd = e;
  endtask

  initial begin
    RST = 1'b1; Req = 1'b0; WEn = 1'b0; Size = 2'b00; Unsigned = 1'b0;
    Address = 32'd0; Wdata = 32'd0;
    model_rd = 32'd0;
    #1;
    check("rst_busy",  {31'd0, Busy},  32'd0);
    check("rst_ready", {31'd0, Ready}, 32'd0);
    check("rst_fault", {31'd0, Fault}, 32'd0);
    check("rst_rdata", Rdata, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    access("sw0",  1'b1, 2'b10, 1'b0, 32'd0, 32'h8C610001, 32'd0, 1'b0);
    access("lw0",  1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'h8C610001, 1'b0);
    access("sw4",  1'b1, 2'b10, 1'b0, 32'd4, 32'h11223344, 32'd0, 1'b0);
    access("sb5",  1'b1, 2'b00, 1'b0, 32'd5, 32'h12345680, 32'd0, 1'b0);
    access("lbs5", 1'b0, 2'b00, 1'b0, 32'd5, 32'd0, 32'hFFFFFF80, 1'b0);
    access("lbu5", 1'b0, 2'b00, 1'b1, 32'd5, 32'd0, 32'h00000080, 1'b0);
    access("lw4a", 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 32'h11803344, 1'b0);
    access("sh6",  1'b1, 2'b01, 1'b0, 32'd6, 32'hDEAD1234, 32'd0, 1'b0);
    access("lw4b", 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 32'h11801234, 1'b0);
    access("lhs6", 1'b0, 2'b01, 1'b0, 32'd6, 32'd0, 32'h00001234, 1'b0);
    access("lhs0", 1'b0, 2'b01, 1'b0, 32'd0, 32'd0, 32'hFFFF8C61, 1'b0);
    access("lhu0", 1'b0, 2'b01, 1'b1, 32'd0, 32'd0, 32'h00008C61, 1'b0);

`ifdef DMEM_FAULT_CHECK_EN
    access("f_lw2",   1'b0, 2'b10, 1'b0, 32'd2, 32'd0, 32'd0, 1'b1);
    access("lw0_ok",  1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'h8C610001, 1'b0);
    access("f_swtop", 1'b1, 2'b10, 1'b0, 32'(DEPTH), 32'hFFFFFFFF, 32'd0, 1'b1);
    access("f_sh1",   1'b1, 2'b01, 1'b0, 32'd1, 32'h0000FFFF, 32'd0, 1'b1);
    access("f_sw126", 1'b1, 2'b10, 1'b0, 32'(DEPTH - 2), 32'hFFFFFFFF, 32'd0, 1'b1);
    access("f_lres",  1'b0, 2'b11, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    access("f_sres",  1'b1, 2'b11, 1'b0, 32'd4, 32'hFFFFFFFF, 32'd0, 1'b1);
    access("lw0_chk", 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'h8C610001, 1'b0);
    access("lw4_chk", 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 32'h11801234, 1'b0);
`else
    access("sw126",  1'b1, 2'b10, 1'b0, 32'(DEPTH - 2), 32'hAABBCCDD, 32'd0, 1'b0);
    access("lb126",  1'b0, 2'b00, 1'b1, 32'(DEPTH - 2), 32'd0, 32'h000000AA, 1'b0);
    access("lb127",  1'b0, 2'b00, 1'b1, 32'(DEPTH - 1), 32'd0, 32'h000000BB, 1'b0);
    access("lhu0w",  1'b0, 2'b01, 1'b1, 32'd0, 32'd0, 32'h0000CCDD, 1'b0);
    access("lw0w",   1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'hCCDD0001, 1'b0);
    access("lw126",  1'b0, 2'b10, 1'b0, 32'(DEPTH - 2), 32'd0, 32'hAABBCCDD, 1'b0);
    access("lres4",  1'b0, 2'b11, 1'b0, 32'd4, 32'd0, 32'h11801234, 1'b0);
    access("lhs5",   1'b0, 2'b01, 1'b0, 32'd5, 32'd0, 32'hFFFF8012, 1'b0);
`endif

    access("sw8",  1'b1, 2'b10, 1'b0, 32'd8, 32'h01020304, 32'd0, 1'b0);
    access("lw8",  1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 32'h01020304, 1'b0);

    // Accept a store, then reset one cycle later while it is in flight.
    Req = 1'b1; WEn = 1'b1; Size = 2'b10; Unsigned = 1'b0;
    Address = 32'd8; Wdata = 32'hCAFEBABE;
    @(posedge CLK);
    #1;
    Req = 1'b0;
    @(posedge CLK);
    #1;
    check("mid_busy", {31'd0, Busy}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("arst_busy",  {31'd0, Busy},  32'd0);
    check("arst_ready", {31'd0, Ready}, 32'd0);
    check("arst_rdata", Rdata, 32'd0);
    check("arst_state", {30'd0, dbg_state}, 32'd0);
    model_rd = 32'd0;
    @(negedge CLK);
    RST = 1'b0;
    access("lw8_old", 1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 32'h01020304, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
